// File: rtl/triangle_mem_arbiter.sv
// Round-robin arbiter sharing one triangle memory read port between NUM_CORE
// intersection cores; one read per grant, response captured and broadcast.
module triangle_mem_arbiter #(
    parameter int NUM_CORE     = 4,
    parameter int NUM_TRIANGLE = 512,
    parameter int TIMEOUT      = 64,
    localparam int BIT_TRIANGLE = $clog2(NUM_TRIANGLE)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_CORE-1:0]            req_core,
    input  logic [NUM_CORE*BIT_TRIANGLE-1:0] tid_core,
    output logic [NUM_CORE-1:0]            done_core,
    output logic                           not_valid_core,
    output logic [95:0]                    vertex0_core,
    output logic [95:0]                    vertex1_core,
    output logic [95:0]                    vertex2_core,
    output logic [31:0]                    sid_core,
    input  logic                           load_busy,
    output logic                           re_mem,
    output logic [BIT_TRIANGLE-1:0]        tid_mem,
    input  logic                           rdy_mem,
    input  logic                           not_valid_mem,
    input  logic [95:0]                    vertex0_mem,
    input  logic [95:0]                    vertex1_mem,
    input  logic [95:0]                    vertex2_mem,
    input  logic [31:0]                    sid_mem,
    output logic                           timeout_err
);

    localparam int GW = (NUM_CORE > 1) ? $clog2(NUM_CORE) : 1;
    localparam int CW = $clog2(TIMEOUT) + 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t                  state, state_nxt;
    logic [GW-1:0]           grant, rr_ptr, pick;
    logic                    pick_vld;
    logic [NUM_CORE-1:0]     req_masked, done_last;
    logic [CW-1:0]           wait_cnt;
    logic                    nv_flag;
    logic [GW:0]             scan;
    logic [BIT_TRIANGLE-1:0] tid_arr [NUM_CORE];

    for (genvar g = 0; g < NUM_CORE; g++) begin : g_tid
        assign tid_arr[g] = tid_core[g*BIT_TRIANGLE +: BIT_TRIANGLE];
    end

    // Scan downward so the requester closest at/after rr_ptr is assigned last and wins.
    always_comb begin
        pick       = '0;
        pick_vld   = 1'b0;
        scan       = '0;
        req_masked = req_core & ~done_last;
        for (int i = NUM_CORE - 1; i >= 0; i--) begin
            scan = {1'b0, rr_ptr} + (GW+1)'(i);
            if (scan >= (GW+1)'(NUM_CORE))
                scan = scan - (GW+1)'(NUM_CORE);
            if (req_masked[scan[GW-1:0]]) begin
                pick     = scan[GW-1:0];
                pick_vld = 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt      = state;
        re_mem         = 1'b0;
        done_core      = '0;
        not_valid_core = 1'b0;
        case (state)
            IDLE:  if (!load_busy && pick_vld) state_nxt = ISSUE;
            ISSUE: begin
                re_mem    = 1'b1;
                state_nxt = WAIT;
            end
            WAIT:  if (not_valid_mem || rdy_mem || wait_cnt == CW'(TIMEOUT - 1))
                       state_nxt = RESP;
            RESP: begin
                done_core[grant] = 1'b1;
                not_valid_core   = nv_flag;
                state_nxt        = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            grant        <= '0;
            rr_ptr       <= '0;
            tid_mem      <= '0;
            wait_cnt     <= '0;
            nv_flag      <= 1'b0;
            done_last    <= '0;
            timeout_err  <= 1'b0;
            vertex0_core <= '0;
            vertex1_core <= '0;
            vertex2_core <= '0;
            sid_core     <= '0;
        end else begin
            state     <= state_nxt;
            done_last <= done_core;
            case (state)
                IDLE: if (state_nxt == ISSUE) begin
                    grant   <= pick;
                    tid_mem <= tid_arr[pick];
                end
                ISSUE: wait_cnt <= '0;
                WAIT: begin
                    if (wait_cnt != '1)
                        wait_cnt <= wait_cnt + CW'(1);
                    // not_valid takes priority over a simultaneous rdy
                    if (not_valid_mem) begin
                        nv_flag <= 1'b1;
                    end else if (rdy_mem) begin
                        vertex0_core <= vertex0_mem;
                        vertex1_core <= vertex1_mem;
                        vertex2_core <= vertex2_mem;
                        sid_core     <= sid_mem;
                        nv_flag      <= 1'b0;
                    end else if (wait_cnt == CW'(TIMEOUT - 1)) begin
                        nv_flag     <= 1'b1;
                        timeout_err <= 1'b1;
                    end
                end
                RESP: rr_ptr <= (grant == GW'(NUM_CORE - 1)) ? '0 : grant + GW'(1);
                default: ;
            endcase
        end
    end

endmodule
